// File: rtl/rotate_7seg_pkg.sv
// Shared constants and state type for the rotating-ring 7-segment animator.
package rotate_7seg_pkg;

    localparam logic [7:0] TOP_PAT = 8'b10100011;
    localparam logic [7:0] BOT_PAT = 8'b10011100;
    localparam logic [7:0] BLANK   = 8'hFF;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/rotate_ring_7seg_step_prescaler.sv
// Clock-enable generator for the ring animator: one-cycle tick every eff_period
// enabled clocks. The count is frozen when run=0 and forced to zero by clear.
module step_prescaler #(
    parameter int PERIOD_W = 27
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] count_d;
    logic [PERIOD_W-1:0] last_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // >= rather than == so a period lowered below the running count ticks at once
    always_comb begin
        last_count = (period == '0) ? '0 : period - PERIOD_W'(1);
        tick       = run && (count_q >= last_count);
        count_d    = count_q;
        if (clear || tick) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/rotate_ring_7seg.sv
// Rotating "circle" animator: one segment pattern travels around a ring of
// 2*N_DIGITS positions (top row left to right, bottom row right to left).
//
// state | meaning
// OFF   | en=0; display blank, position and prescaler held at 0
// RUN   | en=1, hold=0; position advances on every prescaler tick
// HOLD  | en=1, hold=1; prescaler frozen, position advances on step=1
module rotate_ring_7seg
    import rotate_7seg_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    parameter  int N_OFF    = 4,
    parameter  int PERIOD_W = 27,
    localparam int RING     = 2 * N_DIGITS,
    localparam int POS_W    = (RING > 2) ? $clog2(RING) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                hold,
    input  logic                step,
    input  logic                cw,
    input  logic [PERIOD_W-1:0] period,
    output logic [7:0]          cathodes,
    output logic [N_DIGITS-1:0] anodes,
    output logic [N_OFF-1:0]    always_off_an,
    output logic [POS_W-1:0]    pos,
    output logic                wrap
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(RING - 1);

    state_e              state_q;
    state_e              state_d;
    logic [POS_W-1:0]    pos_q;
    logic [POS_W-1:0]    pos_d;
    logic                wrap_q;
    logic                wrap_d;
    logic [7:0]          cathodes_q;
    logic [7:0]          cathodes_d;
    logic [N_DIGITS-1:0] anodes_q;
    logic [N_DIGITS-1:0] anodes_d;

    logic active;
    logic run;
    logic clear;
    logic tick;
    logic step_now;
    int   digit;

    // A fresh OFF->RUN/HOLD entry only presents position 0; stepping starts next clock.
    assign active = en && (state_q != OFF);
    assign run    = active && !hold;
    assign clear  = !active;

    step_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .run    (run),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = OFF;
        end else if (hold) begin
            state_d = HOLD;
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        step_now = tick || (active && hold && step);

        pos_d = pos_q;
        if (!active) begin
            pos_d = '0;
        end else if (step_now) begin
            if (cw) begin
                pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
            end
        end

        wrap_d = step_now && (cw ? (pos_q == LAST_POS) : (pos_q == '0));

        // Decode from the next position so the pins change on the same edge as pos.
        digit      = 0;
        cathodes_d = BLANK;
        anodes_d   = '1;
        if (state_d != OFF) begin
            if (int'(pos_d) < N_DIGITS) begin
                digit      = int'(pos_d);
                cathodes_d = TOP_PAT;
            end else begin
                digit      = RING - 1 - int'(pos_d);
                cathodes_d = BOT_PAT;
            end
            for (int i = 0; i < N_DIGITS; i++) begin
                if (i == N_DIGITS - 1 - digit) begin
                    anodes_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q      <= '0;
            wrap_q     <= 1'b0;
            cathodes_q <= BLANK;
            anodes_q   <= '1;
        end else begin
            pos_q      <= pos_d;
            wrap_q     <= wrap_d;
            cathodes_q <= cathodes_d;
            anodes_q   <= anodes_d;
        end
    end

    assign pos           = pos_q;
    assign wrap          = wrap_q;
    assign cathodes      = cathodes_q;
    assign anodes        = anodes_q;
    assign always_off_an = '1;

endmodule

// File: tb/tb_rotate_ring_7seg.sv
// Bench for rotate_ring_7seg: a 4-digit and a 6-digit instance share stimulus
// and are compared every clock against a ring-arithmetic reference model.
module tb_rotate_ring_7seg;

    localparam int PW = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          hold;
    logic          step;
    logic          cw;
    logic [PW-1:0] period;

    logic [7:0] cath4, cath6;
    logic [3:0] an4;
    logic [5:0] an6;
    logic [3:0] off4;
    logic [1:0] off6;
    logic [2:0] pos4;
    logic [3:0] pos6;
    logic       wrap4, wrap6;

    logic [19:0] obs4;
    logic [20:0] obs6;
    assign obs4 = {pos4, an4, cath4, wrap4, off4};
    assign obs6 = {pos6, an6, cath6, wrap6, off6};

    int n_cmp = 0;
    int n_bad = 0;

    bit m_on;
    int m_cnt;
    int m_pos[2];
    bit m_wrap[2];
    int ndig[2] = '{4, 6};

    rotate_ring_7seg #(.N_DIGITS(4), .N_OFF(4), .PERIOD_W(PW)) dut4 (
        .clk(clk), .reset(rst), .en(en), .hold(hold), .step(step), .cw(cw),
        .period(period), .cathodes(cath4), .anodes(an4), .always_off_an(off4),
        .pos(pos4), .wrap(wrap4)
    );

    rotate_ring_7seg #(.N_DIGITS(6), .N_OFF(2), .PERIOD_W(PW)) dut6 (
        .clk(clk), .reset(rst), .en(en), .hold(hold), .step(step), .cw(cw),
        .period(period), .cathodes(cath6), .anodes(an6), .always_off_an(off6),
        .pos(pos6), .wrap(wrap6)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_on  = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_pos[k]  = 0;
            m_wrap[k] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit adv;
        int eff;
        int r;
        adv = 1'b0;
        if (!en) begin
            model_reset();
            return;
        end
        if (!m_on) begin
            model_reset();
            m_on = 1'b1;
            return;
        end
        if (hold) begin
            adv = step;
        end else begin
            eff = (period == 0) ? 1 : int'(period);
            if (m_cnt >= eff - 1) begin
                m_cnt = 0;
                adv   = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            r = 2 * ndig[k];
            m_wrap[k] = 1'b0;
            if (adv) begin
                m_wrap[k] = cw ? (m_pos[k] == r - 1) : (m_pos[k] == 0);
                m_pos[k]  = cw ? (m_pos[k] + 1) % r : (m_pos[k] + r - 1) % r;
            end
        end
    endfunction

    function automatic logic [5:0] exp_an(int k);
        logic [5:0] a;
        int n;
        int d;
        a = '1;
        if (m_on) begin
            n = ndig[k];
            d = (m_pos[k] < n) ? m_pos[k] : 2 * n - 1 - m_pos[k];
            a[n - 1 - d] = 1'b0;
        end
        return a;
    endfunction

    function automatic logic [7:0] exp_cath(int k);
        if (!m_on) return 8'hFF;
        return (m_pos[k] < ndig[k]) ? 8'hA3 : 8'h9C;
    endfunction

    function automatic logic [19:0] exp4();
        logic [5:0] a;
        a = exp_an(0);
        return {3'(m_pos[0]), a[3:0], exp_cath(0), m_wrap[0], 4'hF};
    endfunction

    function automatic logic [20:0] exp6();
        return {4'(m_pos[1]), exp_an(1), exp_cath(1), m_wrap[1], 2'b11};
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        int wraps;
        rst = 1'b1; en = 1'b1; hold = 1'b0; step = 1'b0; cw = 1'b1; period = 3;
        model_reset();
        #12;
        n_cmp++;
        if (obs4 !== {3'd0, 4'hF, 8'hFF, 1'b0, 4'hF}) begin
            n_bad++;
            $display("FAIL reset_blank got %h want %h", obs4, {3'd0, 4'hF, 8'hFF, 1'b0, 4'hF});
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        n_cmp++;
        if ({pos4, an4, cath4} !== {3'd0, 4'b0111, 8'hA3}) begin
            n_bad++;
            $display("FAIL reset_first_pos got %h want %h", {pos4, an4, cath4}, {3'd0, 4'b0111, 8'hA3});
        end
        wraps = 0;
        for (int i = 0; i < 26; i++) begin
            cycle();
            if (wrap4) wraps++;
            n_cmp++;
            if (obs4 !== exp4() || obs6 !== exp6()) begin
                n_bad++;
                $display("FAIL reset_run cyc %0d got %h/%h want %h/%h", i, obs4, obs6, exp4(), exp6());
            end
            if (m_pos[0] == 4) begin
                n_cmp++;
                if ({an4, cath4} !== {4'b1110, 8'h9C}) begin
                    n_bad++;
                    $display("FAIL pos4_decode got %h want %h", {an4, cath4}, {4'b1110, 8'h9C});
                end
            end
        end
        n_cmp++;
        if (wraps != 1) begin
            n_bad++;
            $display("FAIL reset_wrap_count got %0d want 1", wraps);
        end
    endtask

    task automatic test_ccw();
        en = 1'b0;
        cycle();
        en = 1'b1; cw = 1'b0; period = 1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++;
            if (obs4 !== exp4() || obs6 !== exp6()) begin
                n_bad++;
                $display("FAIL ccw cyc %0d got %h/%h want %h/%h", i, obs4, obs6, exp4(), exp6());
            end
            if (i == 0) begin
                n_cmp++;
                if ({pos4, an4, cath4, wrap4} !== {3'd7, 4'b0111, 8'h9C, 1'b1}) begin
                    n_bad++;
                    $display("FAIL ccw_pos7 got %h want %h", {pos4, an4, cath4, wrap4}, {3'd7, 4'b0111, 8'h9C, 1'b1});
                end
            end
        end
    endtask

    task automatic test_hold();
        int budget;
        cw = 1'b1; period = 4; hold = 1'b0; step = 1'b0;
        budget = 0;
        while (!(m_pos[0] == 2 && m_cnt == 1) && budget < 200) begin
            cycle();
            budget++;
        end
        n_cmp++;
        if (budget >= 200 || pos4 !== 3'd2) begin
            n_bad++;
            $display("FAIL hold_setup got pos %0d want 2 (cycles %0d)", pos4, budget);
        end
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step = (i == 3 || i == 6);
            cycle();
            n_cmp++;
            if (obs4 !== exp4() || obs6 !== exp6()) begin
                n_bad++;
                $display("FAIL hold cyc %0d got %h/%h want %h/%h", i, obs4, obs6, exp4(), exp6());
            end
        end
        step = 1'b0;
        n_cmp++;
        if (pos4 !== 3'd4) begin
            n_bad++;
            $display("FAIL hold_steps got %0d want 4", pos4);
        end
        hold = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (pos4 !== 3'd4) begin
            n_bad++;
            $display("FAIL hold_resume_early got %0d want 4", pos4);
        end
        cycle();
        n_cmp++;
        if (pos4 !== 3'd5 || obs4 !== exp4()) begin
            n_bad++;
            $display("FAIL hold_resume_tick got %0d want 5", pos4);
        end
    endtask

    task automatic test_period();
        int budget;
        int p;
        period = 0; cw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            p = m_pos[0];
            cycle();
            n_cmp++;
            if (obs4 !== exp4() || obs6 !== exp6() || int'(pos4) != (p + 1) % 8) begin
                n_bad++;
                $display("FAIL period0 cyc %0d got %h want %h", i, obs4, exp4());
            end
        end
        period = 100;
        budget = 0;
        while (m_cnt != 50 && budget < 300) begin
            cycle();
            budget++;
        end
        p = m_pos[0];
        period = 2;
        cycle();
        n_cmp++;
        if (budget >= 300 || int'(pos4) != (p + 1) % 8 || obs4 !== exp4()) begin
            n_bad++;
            $display("FAIL period_drop got %0d want %0d", pos4, (p + 1) % 8);
        end
    endtask

    task automatic test_en_drop();
        int budget;
        period = 1; cw = 1'b1; hold = 1'b0;
        budget = 0;
        while (m_pos[0] != 5 && budget < 50) begin
            cycle();
            budget++;
        end
        en = 1'b0;
        cycle();
        n_cmp++;
        if (budget >= 50 || obs4 !== {3'd0, 4'hF, 8'hFF, 1'b0, 4'hF}) begin
            n_bad++;
            $display("FAIL en_drop got %h want %h", obs4, {3'd0, 4'hF, 8'hFF, 1'b0, 4'hF});
        end
        en = 1'b1; period = 3;
        cycle();
        n_cmp++;
        if ({pos4, an4, cath4} !== {3'd0, 4'b0111, 8'hA3}) begin
            n_bad++;
            $display("FAIL reenable got %h want %h", {pos4, an4, cath4}, {3'd0, 4'b0111, 8'hA3});
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if (obs4 !== exp4() || pos4 !== ((i >= 2) ? 3'd1 : 3'd0)) begin
                n_bad++;
                $display("FAIL reenable_step cyc %0d got %h want %h", i, obs4, exp4());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            hold   = ($urandom_range(0, 4) == 0);
            step   = $urandom_range(0, 1) == 1;
            cw     = $urandom_range(0, 1) == 1;
            period = PW'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                n_cmp++;
                if (obs4 !== exp4() || obs6 !== exp6()) begin
                    n_bad++;
                    $display("FAIL rand_async_reset got %h/%h want %h/%h", obs4, obs6, exp4(), exp6());
                end
                #1;
                rst = 1'b0;
            end
            cycle();
            n_cmp++;
            if (obs4 !== exp4() || obs6 !== exp6()) begin
                n_bad++;
                $display("FAIL random cyc %0d got %h/%h want %h/%h", i, obs4, obs6, exp4(), exp6());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ccw();
        test_hold();
        test_period();
        test_en_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rotate_ring_7seg.md
Name: rotate_ring_7seg

Overview:
- Parametrised successor to the team's single-speed rotating-circle 7-segment animator.
- Drives one "circle" segment pattern around a ring of 2*N_DIGITS positions: top circles left→right, then bottom circles right→left.
- Runtime-programmable step period, direction, hold/single-step and a wrap pulse.
- Fully synchronous to one clock; an internal enable-tick prescaler replaces any derived clock. Sits directly in front of the board's anode/cathode pins.

Parameters:
- N_DIGITS, 4, number of animated digits (≥1)
- N_OFF, 4, number of unused digits held dark on always_off_an (≥1)
- PERIOD_W, 27, width of the step-period input
- POS_W, $clog2(2*N_DIGITS) (min 1), localparam, width of the position register

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  animation enable; 0 blanks the display and returns to position 0
- hold  in  1  freeze the animation at the current position
- step  in  1  while held: advance one position per clock in which step=1
- cw  in  1  1 = clockwise (pos+1), 0 = counter-clockwise (pos-1)
- period  in  PERIOD_W  clocks per automatic step; 0 is treated as 1
- cathodes  out  8  active-low segment pattern
- anodes  out  N_DIGITS  active-low digit select; bit N_DIGITS-1 = leftmost digit
- always_off_an  out  N_OFF  constant all-ones
- pos  out  POS_W  current ring position
- wrap  out  1  one-clock pulse on ring wrap

Behaviour:
- Reset (async): state=OFF, pos=0, prescaler count=0, anodes all 1, cathodes 8'hFF, always_off_an all 1, wrap=0.
- always_off_an is all 1 in every state.
- States:
  - OFF: en=0.
  - RUN: en=1 and hold=0.
  - HOLD: en=1 and hold=1.
  - en=0 overrides everything. Any state with en=0 goes to OFF next clock: pos←0, count←0, outputs blank.
- OFF→RUN/HOLD: on the first clock with en=1, outputs show position 0, count←0. The first automatic step occurs eff_period clocks later, where eff_period = (period==0) ? 1 : period.
- Prescaler (RUN only):
  - tick when count ≥ eff_period-1, then count←0; otherwise count←count+1.
  - The ≥ compare means lowering period below the current count produces a tick on the next clock, with no long wrap.
  - In HOLD the count is frozen; it resumes on return to RUN.
- Step rule, applied on a tick in RUN or on step=1 in HOLD:
  - cw=1: pos←(pos==2N-1)?0:pos+1
  - cw=0: pos←(pos==0)?2N-1:pos-1
  - cw is sampled at the step edge, so a direction change takes effect at the next step with no skipped position.
  - step is ignored in RUN and OFF.
- wrap: 1 for exactly the clock following a step that moves 2N-1→0 (cw) or 0→2N-1 (ccw); 0 otherwise, including on en-forced return to 0.
- Decode (registered; updates on the same edge as pos, zero added latency):
  - p<N: digit d=p (0 = leftmost), cathodes=TOP_PAT.
  - p≥N: d=2N-1-p, cathodes=BOT_PAT.
  - anodes = all 1 except bit (N_DIGITS-1-d) = 0. Exactly one anode is low whenever en=1.
- N_DIGITS=1: ring has 2 positions (top, bottom) on the single digit; cw and ccw give the same sequence.
- Reset asserted mid-animation: immediate blank, pos=0; resumes from position 0 after deassertion if en=1.

Decomposition:
- Package rotate_7seg_pkg:
  - TOP_PAT=8'b10100011, BOT_PAT=8'b10011100, BLANK=8'hFF
  - state enum {OFF, RUN, HOLD}
- Sub-module step_prescaler: count register, eff_period compare, tick output, freeze/clear inputs. It is a clock-enable generator, never a derived clock.
- Ring position, state machine and decode stay in rotate_ring_7seg.

Test Plan:
- Reset with en=1, period=3, cw=1 → outputs blank during reset. After release: anodes=4'b0111, cathodes=8'hA3, pos=0. pos then advances 0→1→2…→7→0 every 3 clocks. wrap pulses once at the 7→0 edge; at pos=4 anodes=4'b1110, cathodes=8'h9C.
- cw=0 from pos=0, period=1 → pos sequence 7,6,5…0 on consecutive clocks. wrap pulses on the 0→7 step. At pos=7: anodes=4'b0111, cathodes=8'h9C.
- RUN at pos=2 with count=1, period=4; assert hold for 10 clocks with step pulsed twice → pos=4, no automatic steps. Release hold → next tick after 3 more clocks (count resumes from 1).
- period=0 → steps every clock, identical to period=1. Then period changed 100→2 while count=50 → tick on the next clock, count←0.
- en dropped at pos=5 → next clock: pos=0, anodes all 1, cathodes 8'hFF, wrap=0. Re-enable → position 0 shown, first step after eff_period clocks.
- N_DIGITS=6, N_OFF=2 build → ring of 12 positions. pos=11 drives anodes=6'b011111 with BOT_PAT; always_off_an=2'b11 throughout.
